fetch_queue: RTL and testbench

// - Instruction queue between the fetch stage and the decode stage. Holds fetched {instr, pc, br_pred} entries.
// - Fetch keeps running while decode stalls; short fetch gaps do not starve decode.
// - Handshake on both sides: valid/ack. A beat transfers in a cycle where valid and ack are both high.
// - Flush discards every entry; used on a branch or a flush.
//

---
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue holding {instr, pc, br_pred} entries with valid/ack on both sides.
// Define FETCHQ_BYPASS_EN to add a zero-latency path through an empty queue and push-while-full-pop.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [31:0]                instr_i,
  input  logic [31:0]                pc_i,
  input  logic                       br_pred_i,
  output logic                       ack_o,
  output logic                       valid_o,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_o,
  output logic                       br_pred_o,
  input  logic                       ack_i,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br_pred;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [CW-1:0]   count_q;

  logic   empty;
  logic   full;
  logic   push;
  logic   pop;
  logic   pass_path;
  logic   do_write;
  logic   do_read;
  entry_t in_entry;
  entry_t head;

  // Reset gates the combinational outputs so they clear the instant rst_i rises.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_COUNT);
    in_entry = '{instr: instr_i, pc: pc_i, br_pred: br_pred_i};
`ifdef FETCHQ_BYPASS_EN
    pass_path = empty & !flush_i & !rst_i;
    ack_o     = !rst_i & valid_i & !flush_i & (!full | ack_i);
    valid_o   = pass_path ? valid_i : (!rst_i & !empty & !flush_i);
    head      = pass_path ? in_entry : (empty ? '0 : mem[rd_q]);
`else
    pass_path = 1'b0;
    ack_o     = !rst_i & valid_i & !flush_i & !full;
    valid_o   = !rst_i & !empty & !flush_i;
    head      = empty ? '0 : mem[rd_q];
`endif
    push     = valid_i & ack_o;
    pop      = valid_o & ack_i;
    // A beat that passes straight through an empty queue is never stored.
    do_write = push & !(pop & pass_path);
    do_read  = pop & !pass_path;
  end

  assign instr_o   = head.instr;
  assign pc_o      = head.pc;
  assign br_pred_o = head.br_pred;
  assign level_o   = count_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_write) wr_q <= wr_q + 1'b1;
      if (do_read)  rd_q <= rd_q + 1'b1;
      case ({do_write, do_read})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; count_q alone decides which slots hold live entries.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_q] <= in_entry;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
// Honours FETCHQ_BYPASS_EN the same way the design does.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [31:0]   instr_i = '0;
  logic [31:0]   pc_i = '0;
  logic          br_pred_i = 1'b0;
  logic          ack_i = 1'b0;
  logic          ack_o;
  logic          valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   pc_o;
  logic          br_pred_o;
  logic [LW-1:0] level_o;

  int errors = 0;
  int checks = 0;

  logic [64:0] model_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .instr_i(instr_i), .pc_i(pc_i), .br_pred_i(br_pred_i), .ack_o(ack_o),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .br_pred_o(br_pred_o),
    .ack_i(ack_i), .level_o(level_o)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents plus the acceptance and visibility rules.
  function automatic logic bypass_active();
    return BYP && (model_q.size() == 0) && !flush_i;
  endfunction

  function automatic logic exp_ack();
    return valid_i && !flush_i && ((model_q.size() < DEPTH) || (BYP && ack_i));
  endfunction

  function automatic logic exp_valid();
    if (bypass_active()) return valid_i;
    return (model_q.size() != 0) && !flush_i;
  endfunction

  function automatic logic [64:0] exp_head();
    if (bypass_active()) return {instr_i, pc_i, br_pred_i};
    if (model_q.size() == 0) return '0;
    return model_q[0];
  endfunction

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic br, input logic ack, input logic fl);
    valid_i = v; instr_i = ins; pc_i = pc; br_pred_i = br; ack_i = ack; flush_i = fl;
  endtask

  task automatic advance();
    logic bp, pop, push;
    logic [64:0] e;
    bp   = bypass_active();
    pop  = exp_valid() && ack_i;
    push = valid_i && exp_ack();
    e    = {instr_i, pc_i, br_pred_i};
    if (flush_i) model_q.delete();
    else if (!(bp && pop && push)) begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) begin
      @(negedge clk); advance();
    end
    checks++; if (model_q.size() != 0) begin errors++; $display("[TB] FAIL drain_bound: left %0d expected 0", model_q.size()); end
    checks++; if (level_o !== LW'(0)) begin errors++; $display("[TB] FAIL drain_level: got %0d expected 0", level_o); end
  endtask

  task automatic test_reset();
    set_in(1'b1, 32'h13, 32'h11, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", ack_o); end
    checks++; if (level_o !== LW'(0)) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", pc_o); end
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    checks++; if (ack_o !== 1'b1) begin errors++; $display("[TB] FAIL release_ack: got %b expected 1", ack_o); end
    @(negedge clk); advance();
    set_in(1'b1, 32'h17, 32'h15, 1'b1, 1'b0, 1'b0);
    @(negedge clk); advance();
    checks++; if (level_o !== LW'(2)) begin errors++; $display("[TB] FAIL pre_async_level: got %0d expected 2", level_o); end
    rst_i = 1'b1;
    #1;
    model_q.delete();
    checks++; if (level_o !== LW'(0) || valid_o !== 1'b0 || ack_o !== 1'b0 || pc_o !== 32'h0)
      begin errors++; $display("[TB] FAIL async_reset: got level=%0d valid=%b ack=%b pc=%h expected 0", level_o, valid_o, ack_o, pc_o); end
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, $urandom, 32'(4 * k), ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (ack_o !== 1'b1) begin errors++; $display("[TB] FAIL fill_ack%0d: got %b expected 1", k, ack_o); end
      advance();
    end
    set_in(1'b1, $urandom, 32'h10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (level_o !== LW'(4)) begin errors++; $display("[TB] FAIL full_level: got %0d expected 4", level_o); end
    checks++; if (ack_o !== 1'b0) begin errors++; $display("[TB] FAIL full_ack: got %b expected 0", ack_o); end
    advance();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (valid_o !== 1'b1 || pc_o !== 32'(4 * k)) begin errors++; $display("[TB] FAIL drain_pc%0d: got valid=%b pc=%h expected 1 %h", k, valid_o, pc_o, 32'(4 * k)); end
      checks++; if ({instr_o, pc_o, br_pred_o} !== exp_head()) begin errors++; $display("[TB] FAIL drain_head%0d: got %h expected %h", k, {instr_o, pc_o, br_pred_o}, exp_head()); end
      advance();
    end
    checks++; if (level_o !== LW'(0)) begin errors++; $display("[TB] FAIL drained_level: got %0d expected 0", level_o); end
  endtask

  task automatic test_wrap();
    set_in(1'b1, $urandom, 32'h100, 1'b0, 1'b0, 1'b0);
    @(negedge clk); advance();
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, $urandom, 32'h100 + 32'(4 * (k + 1)), 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (pc_o !== 32'h100 + 32'(4 * k) || level_o !== LW'(1))
        begin errors++; $display("[TB] FAIL wrap%0d: got pc=%h level=%0d expected %h 1", k, pc_o, level_o, 32'h100 + 32'(4 * k)); end
      advance();
    end
    drain();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, $urandom, 32'h20 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
      @(negedge clk); advance();
    end
    set_in(1'b1, 32'h33, 32'h40, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (ack_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_cycle: got ack=%b valid=%b expected 0 0", ack_o, valid_o); end
    advance();
    set_in(1'b1, 32'h33, 32'h40, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (level_o !== LW'(0)) begin errors++; $display("[TB] FAIL flush_level: got %0d expected 0", level_o); end
    checks++; if (ack_o !== 1'b1) begin errors++; $display("[TB] FAIL post_flush_ack: got %b expected 1", ack_o); end
    advance();
    set_in(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h40 || instr_o !== 32'h33 || br_pred_o !== 1'b1)
      begin errors++; $display("[TB] FAIL post_flush_head: got valid=%b pc=%h instr=%h br=%b expected 1 40 33 1", valid_o, pc_o, instr_o, br_pred_o); end
    advance();
    drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, $urandom, 32'h200 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
      @(negedge clk); advance();
    end
    set_in(1'b1, $urandom, 32'h208, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (pc_o !== 32'h200) begin errors++; $display("[TB] FAIL b2b_head: got %h expected 200", pc_o); end
    advance();
    set_in(1'b1, $urandom, 32'h20C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (level_o !== LW'(2)) begin errors++; $display("[TB] FAIL b2b_level: got %0d expected 2", level_o); end
    advance();
    set_in(1'b1, $urandom, 32'h210, 1'b0, 1'b0, 1'b0);
    @(negedge clk); advance();
    set_in(1'b1, $urandom, 32'h214, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (ack_o !== BYP) begin errors++; $display("[TB] FAIL full_pop_ack: got %b expected %b", ack_o, BYP); end
    checks++; if (level_o !== LW'(4)) begin errors++; $display("[TB] FAIL full_pop_level: got %0d expected 4", level_o); end
    advance();
    checks++; if (level_o !== (BYP ? LW'(4) : LW'(3))) begin errors++; $display("[TB] FAIL after_full_pop: got %0d expected %0d", level_o, BYP ? 4 : 3); end
    drain();
  endtask

`ifdef FETCHQ_BYPASS_EN
  task automatic test_bypass();
    set_in(1'b1, 32'h00000013, 32'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (valid_o !== 1'b1 || instr_o !== 32'h13 || pc_o !== 32'h80)
      begin errors++; $display("[TB] FAIL bypass_head: got valid=%b instr=%h pc=%h expected 1 13 80", valid_o, instr_o, pc_o); end
    advance();
    checks++; if (level_o !== LW'(0)) begin errors++; $display("[TB] FAIL bypass_level: got %0d expected 0", level_o); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
      @(negedge clk);
      checks++; if (ack_o !== exp_ack()) begin errors++; $display("[TB] FAIL rand_ack@%0d: got %b expected %b", n, ack_o, exp_ack()); end
      checks++; if (valid_o !== exp_valid()) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %b expected %b", n, valid_o, exp_valid()); end
      checks++; if (level_o !== LW'(model_q.size())) begin errors++; $display("[TB] FAIL rand_level@%0d: got %0d expected %0d", n, level_o, model_q.size()); end
      checks++; if ({instr_o, pc_o, br_pred_o} !== exp_head()) begin errors++; $display("[TB] FAIL rand_head@%0d: got %h expected %h", n, {instr_o, pc_o, br_pred_o}, exp_head()); end
      advance();
    end
    drain();
  endtask

  initial begin
    $display("[TB] fetch_queue bench start (bypass=%0d)", BYP);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_back_to_back();
`ifdef FETCHQ_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
